change_dispenser: RTL and testbench



---
 rtl/vend_pkg.sv | 20 ++
 rtl/change_dispenser_pulse_timer.sv | 35 +++
 rtl/change_dispenser.sv | 145 ++++++++++++++
 tb/tb_change_dispenser.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared types for the change dispenser.
//   disp_state_t : dispenser sequencer states
//   change_t     : change owed, in quarters (0..7)
//   MAX_CHANGE_Q : largest change value a request can carry
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GUFFIN  = 3'd1,
    GAP     = 3'd2,
    HALF    = 3'd3,
    QUARTER = 3'd4,
    DONE    = 3'd5
  } disp_state_t;

  typedef logic [2:0] change_t;

  localparam int MAX_CHANGE_Q = 7;

endpackage

// File: rtl/change_dispenser_pulse_timer.sv
// pulse_timer: loadable down-counter for actuator pulse / gap timing.
//   CLK, RES : clock, synchronous active-high reset
//   load     : load `count` into the counter this edge
//   count    : duration in cycles (>=1)
//   expire   : high for the last cycle of a loaded duration
module pulse_timer #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RES,
  input  logic         load,
  input  logic [W-1:0] count,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = count;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RES) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // A loaded value of N holds the counter in N..1; the cycle showing 1 is
  // the last one, so the owner transitions on the edge that ends it.
  assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: turns a one-cycle vend request into timed, non-overlapping
// actuator pulses: guffin, then half-dollars, then at most one quarter, then a
// one-cycle done strobe.
//   CLK, RES       : clock, synchronous active-high reset
//   vend_req       : request strobe, only honoured in IDLE
//   change_q       : change owed in quarters, sampled with vend_req
//   guffin         : product actuator pulse
//   halfDollar_out : 50c actuator pulse
//   quarter_out    : 25c actuator pulse
//   busy           : sequence in progress (through the done cycle)
//   done           : one-cycle completion strobe
module change_dispenser
  import vend_pkg::*;
#(
  parameter int PULSE_CYCLES = 25_000_000,
  parameter int GAP_CYCLES   = 12_500_000
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       vend_req,
  input  logic [2:0] change_q,
  output logic       guffin,
  output logic       halfDollar_out,
  output logic       quarter_out,
  output logic       busy,
  output logic       done
);

  localparam int MAX_PG = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW     = $clog2(MAX_PG + 1);

  disp_state_t state_q, state_d;
  logic [1:0]  halves_q, halves_d;
  logic        quarter_q, quarter_d;
  logic        guffin_q, guffin_d;
  logic        half_q, half_d;
  logic        qtr_q, qtr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  change_t     req_change;
  logic        tmr_load;
  logic [TW-1:0] tmr_count;
  logic        tmr_expire;

  assign req_change = change_q;

  pulse_timer #(.W(TW)) u_timer (
    .CLK    (CLK),
    .RES    (RES),
    .load   (tmr_load),
    .count  (tmr_count),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    halves_d  = halves_q;
    quarter_d = quarter_q;
    case (state_q)
      IDLE: begin
        if (vend_req) begin
          // Greedy split: upper two bits are half-dollars, LSB the odd quarter.
          halves_d  = req_change[2:1];
          quarter_d = req_change[0];
          state_d   = GUFFIN;
        end
      end
      GUFFIN, HALF, QUARTER: begin
        if (tmr_expire) state_d = GAP;
      end
      GAP: begin
        if (tmr_expire) begin
          if (halves_q != 2'd0) begin
            state_d  = HALF;
            halves_d = halves_q - 2'd1;
          end else if (quarter_q) begin
            state_d   = QUARTER;
            quarter_d = 1'b0;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every timed state is entered from a different state, so a state change
  // is exactly the reload point and the counter never needs to wrap.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_count = TW'(PULSE_CYCLES);
    if (state_d != state_q) begin
      case (state_d)
        GUFFIN, HALF, QUARTER: tmr_load = 1'b1;
        GAP: begin
          tmr_load  = 1'b1;
          tmr_count = TW'(GAP_CYCLES);
        end
        default: tmr_load = 1'b0;
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as the
  // state register and are glitch-free flop outputs.
  always_comb begin
    guffin_d = (state_d == GUFFIN);
    half_d   = (state_d == HALF);
    qtr_d    = (state_d == QUARTER);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q   <= IDLE;
      halves_q  <= 2'd0;
      quarter_q <= 1'b0;
      guffin_q  <= 1'b0;
      half_q    <= 1'b0;
      qtr_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      halves_q  <= halves_d;
      quarter_q <= quarter_d;
      guffin_q  <= guffin_d;
      half_q    <= half_d;
      qtr_q     <= qtr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign guffin         = guffin_q;
  assign halfDollar_out = half_q;
  assign quarter_out    = qtr_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed checks of change_dispenser with P=3, G=2.
// Cycle k of a sequence is the k-th clock period after the period in which
// vend_req is driven; outputs are sampled 1 time unit after each rising edge.
module tb_change_dispenser;
  import vend_pkg::*;

  localparam int P    = 3;
  localparam int G    = 2;
  localparam int SLOT = P + G;

  logic       CLK = 1'b0;
  logic       RES = 1'b1;
  logic       vend_req = 1'b0;
  logic [2:0] change_q = 3'd0;
  logic       guffin, halfDollar_out, quarter_out, busy, done;

  int vectors     = 0;
  int miscompares = 0;

  change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .CLK            (CLK),
    .RES            (RES),
    .vend_req       (vend_req),
    .change_q       (change_q),
    .guffin         (guffin),
    .halfDollar_out (halfDollar_out),
    .quarter_out    (quarter_out),
    .busy           (busy),
    .done           (done)
  );

  always #5 CLK = ~CLK;

  // Expected {guffin, half, quarter, busy, done} in cycle k for change c:
  // slot 0 is the guffin, slots 1..h are half-dollars, then an optional
  // quarter; each slot is P high cycles then G low cycles; done follows.
  function automatic logic [4:0] exp_vec(input logic [2:0] c, input int k);
    int h, qq, n, slot, off;
    logic [4:0] v;
    v    = 5'b0;
    h    = int'(c[2:1]);
    qq   = int'(c[0]);
    n    = 1 + h + qq;
    if (k >= 1 && k <= n * SLOT) begin
      slot = (k - 1) / SLOT;
      off  = (k - 1) % SLOT;
      v[1] = 1'b1;
      if (off < P) begin
        if (slot == 0)      v[4] = 1'b1;
        else if (slot <= h) v[3] = 1'b1;
        else                v[2] = 1'b1;
      end
    end else if (k == n * SLOT + 1) begin
      v[1] = 1'b1;
      v[0] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [4:0] obs();
    return {guffin, halfDollar_out, quarter_out, busy, done};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RES = 1'b1; vend_req = 1'b1; change_q = 3'd7;
    tick(); tick();
    vectors++;
    if (obs() !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 00000", obs());
    end
    vectors++;
    if (dut.state_q !== IDLE) begin
      miscompares++;
      $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE);
    end
    RES = 1'b0; vend_req = 1'b0; change_q = 3'd0;
    for (int k = 0; k < 8; k++) begin
      tick();
      vectors++;
      if (obs() !== 5'b0) begin
        miscompares++;
        $display("FAIL reset_req_dropped: cycle %0d got %b want 00000", k, obs());
      end
    end
  endtask

  task automatic test_change(input logic [2:0] c);
    int n;
    n = 1 + int'(c[2:1]) + int'(c[0]);
    vend_req = 1'b1; change_q = c;
    vectors++;
    if (obs() !== 5'b0) begin
      miscompares++;
      $display("FAIL change%0d_idle: got %b want 00000", c, obs());
    end
    for (int k = 1; k <= n * SLOT + 3; k++) begin
      tick();
      if (k == 1) begin
        vend_req = 1'b0;
        change_q = ~c;   // must not affect the latched counts
      end
      vectors++;
      if (obs() !== exp_vec(c, k)) begin
        miscompares++;
        $display("FAIL change%0d_seq: cycle %0d got %b want %b", c, k, obs(), exp_vec(c, k));
      end
      vectors++;
      if ($countones(obs()[4:2]) > 1) begin
        miscompares++;
        $display("FAIL change%0d_overlap: cycle %0d got %b want at most one actuator", c, k, obs()[4:2]);
      end
    end
    change_q = 3'd0;
  endtask

  task automatic test_ignored_req();
    logic [4:0] e;
    vend_req = 1'b1; change_q = 3'd3;
    for (int t = 1; t <= 17 + 21 + 2; t++) begin
      tick();
      vend_req = 1'b0;
      if (t == 4 || t == 17) begin
        vend_req = 1'b1;
        change_q = 3'd5;
      end
      e = (t < 17) ? exp_vec(3'd3, t) : exp_vec(3'd5, t - 17);
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL ignored_req: cycle %0d got %b want %b", t, obs(), e);
      end
    end
    vend_req = 1'b0; change_q = 3'd0;
  endtask

  task automatic test_reset_mid();
    logic [4:0] e;
    vend_req = 1'b1; change_q = 3'd3;
    for (int t = 1; t <= 20; t++) begin
      tick();
      vend_req = 1'b0;
      RES = (t == 7);
      e = (t <= 7) ? exp_vec(3'd3, t) : 5'b0;
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL reset_mid: cycle %0d got %b want %b", t, obs(), e);
      end
    end
    RES = 1'b0;
    test_change(3'd1);
  endtask

  initial begin
    test_reset();
    test_change(3'd3);
    test_change(3'd0);
    test_change(3'd7);
    test_change(3'd4);
    test_change(3'(MAX_CHANGE_Q - 1));
    test_ignored_req();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
